// File: rtl/checker_hm_arbiter_pkg.sv
// Shared definitions for the host-memory read arbiter: bus widths and FSM state encoding.
package checker_hm_arbiter_pkg;

  localparam int HM_ADDR_W = 64;
  localparam int HM_OFF_W  = 12;
  localparam int HM_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } hm_state_e;

endpackage

// File: rtl/checker_hm_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after i_last (wrapping) wins, one-hot out.
module checker_rr_pick
  import checker_hm_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_win
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  // Walk from farthest to nearest so the nearest requester after i_last overwrites the rest.
  always_comb begin
    o_win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (|(i_req & (ONE << ((int'(i_last) + k) % N_REQ))))
        o_win = ONE << ((int'(i_last) + k) % N_REQ);
    end
  end

endmodule

// File: rtl/checker_hm_arbiter.sv
// Round-robin arbiter sharing one host-memory read engine among N_REQ requesters.
// Define CHECKER_HM_ARB_WATCHDOG_EN to build the WAIT-state watchdog (TIMEOUT cycles).
module checker_hm_arbiter
  import checker_hm_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*HM_ADDR_W-1:0] req_page,
  input  logic [N_REQ*HM_OFF_W-1:0] req_offset,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [HM_DATA_W-1:0]      rsp_data,
  output logic                      rsp_error,
  output logic [HM_ADDR_W-1:0]      hm_page_addr,
  output logic [HM_OFF_W-1:0]       hm_page_offset,
  output logic                      hm_start,
  input  logic                      hm_end,
  input  logic [HM_DATA_W-1:0]      hm_data,
  input  logic                      hm_error,
  input  logic                      hm_timeout,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [15:0]               stat_err_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 4 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("checker_hm_arbiter: parameter out of range");
  end

  hm_state_e              r_state, w_next;
  logic [N_REQ-1:0]       r_grant;
  logic [IDX_W-1:0]       r_last;
  logic [HM_ADDR_W-1:0]   r_page;
  logic [HM_OFF_W-1:0]    r_off;
  logic [HM_DATA_W-1:0]   r_rsp_data;
  logic                   r_rsp_error;
  logic [15:0]            r_err_cnt;

  logic [N_REQ-1:0]       w_win;
  logic [IDX_W-1:0]       w_win_idx;
  logic [HM_ADDR_W-1:0]   w_sel_page;
  logic [HM_OFF_W-1:0]    w_sel_off;
  logic                   w_wd_hit;

  checker_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_win  (w_win)
  );

  always_comb begin
    w_sel_page = '0;
    w_sel_off  = '0;
    w_win_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win[i]) begin
        w_sel_page = req_page[i*HM_ADDR_W +: HM_ADDR_W];
        w_sel_off  = req_offset[i*HM_OFF_W +: HM_OFF_W];
        w_win_idx  = IDX_W'(i);
      end
    end
  end

`ifdef CHECKER_HM_ARB_WATCHDOG_EN
  logic [15:0] r_wd;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                r_wd <= '0;
    else if (r_state == ST_ISSUE)  r_wd <= '0;
    else if (r_state == ST_WAIT)   r_wd <= r_wd + 16'd1;
  end

  assign w_wd_hit = (r_state == ST_WAIT) && (r_wd == 16'(TIMEOUT - 1));
`else
  assign w_wd_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (|req_valid) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (hm_end || w_wd_hit) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_last      <= IDX_W'(N_REQ - 1);
      r_page      <= '0;
      r_off       <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (|req_valid) begin
          r_grant <= w_win;
          r_last  <= w_win_idx;
          r_page  <= w_sel_page;
          r_off   <= w_sel_off;
        end
        // A real completion wins over a watchdog expiry in the same cycle.
        ST_WAIT: if (hm_end) begin
          r_rsp_data  <= hm_data;
          r_rsp_error <= hm_error | hm_timeout;
        end else if (w_wd_hit) begin
          r_rsp_data  <= '0;
          r_rsp_error <= 1'b1;
        end
        ST_RESP: begin
          r_grant <= '0;
          if (r_rsp_error && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ack        = (r_state == ST_ISSUE) ? r_grant : '0;
  assign rsp_valid      = (r_state == ST_RESP)  ? r_grant : '0;
  assign hm_start       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign busy           = (r_state != ST_IDLE);
  assign grant          = r_grant;
  assign rsp_data       = r_rsp_data;
  assign rsp_error      = r_rsp_error;
  assign hm_page_addr   = r_page;
  assign hm_page_offset = r_off;
  assign stat_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_checker_hm_arbiter.sv
// Directed bench for checker_hm_arbiter; responses are checked against a scoreboard queue.
module tb_checker_hm_arbiter;

  localparam int N_REQ   = 3;
  localparam int TIMEOUT = 16;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*64-1:0]  req_page;
  logic [N_REQ*12-1:0]  req_offset;
  logic [N_REQ-1:0]     req_ack, rsp_valid, grant;
  logic [63:0]          rsp_data, hm_page_addr, hm_data;
  logic                 rsp_error, hm_start, hm_end, hm_error, hm_timeout, busy;
  logic [11:0]          hm_page_offset;
  logic [15:0]          stat_err_cnt;

  logic [63:0] pg_a  [N_REQ];
  logic [11:0] off_a [N_REQ];

  typedef struct {
    logic [N_REQ-1:0] g;
    logic [63:0]      d;
    logic             e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 sys_clk = ~sys_clk;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pack
    assign req_page[gi*64 +: 64]   = pg_a[gi];
    assign req_offset[gi*12 +: 12] = off_a[gi];
  end

  checker_hm_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .req_valid      (req_valid),
    .req_page       (req_page),
    .req_offset     (req_offset),
    .req_ack        (req_ack),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .hm_page_addr   (hm_page_addr),
    .hm_page_offset (hm_page_offset),
    .hm_start       (hm_start),
    .hm_end         (hm_end),
    .hm_data        (hm_data),
    .hm_error       (hm_error),
    .hm_timeout     (hm_timeout),
    .grant          (grant),
    .busy           (busy),
    .stat_err_cnt   (stat_err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge sys_clk) begin
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(e.g));
        chk("rsp_data",  rsp_data,        e.d);
        chk("rsp_error", 64'(rsp_error), 64'(e.e));
      end
    end
  end

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (hm_start === 1'b1) found = 1'b1;
    end
    chk({tag, "_start"}, 64'(found), 64'(1));
  endtask

  task automatic txn(input string tag, input logic [N_REQ-1:0] g, input int dly,
                     input logic [63:0] data, input logic er, input logic tm,
                     input logic [N_REQ-1:0] clr, input logic [63:0] pg, input logic [11:0] off);
    sb.push_back('{g, data, er | tm});
    wait_start(tag);
    chk({tag, "_ack"},   64'(req_ack), 64'(g));
    chk({tag, "_grant"}, 64'(grant),   64'(g));
    chk({tag, "_page"},  hm_page_addr, pg);
    chk({tag, "_off"},   64'(hm_page_offset), 64'(off));
    req_valid = req_valid & ~clr;
    repeat (dly) tick();
    hm_end = 1'b1; hm_data = data; hm_error = er; hm_timeout = tm;
    tick();
    hm_end = 1'b0; hm_data = '0; hm_error = 1'b0; hm_timeout = 1'b0;
    chk({tag, "_resp_hs"}, 64'(hm_start), 64'(0));
    tick();
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N_REQ-1:0] g;
    sys_rst_n = 1'b0; req_valid = '0;
    hm_end = 1'b0; hm_data = '0; hm_error = 1'b0; hm_timeout = 1'b0;
    pg_a[0] = '0; pg_a[1] = '0; pg_a[2] = '0;
    off_a[0] = '0; off_a[1] = '0; off_a[2] = '0;
    repeat (2) tick();
    chk("rst_grant",    64'(grant),     64'(0));
    chk("rst_busy",     64'(busy),      64'(0));
    chk("rst_hm_start", 64'(hm_start),  64'(0));
    chk("rst_ack",      64'(req_ack),   64'(0));
    chk("rst_rsp",      64'(rsp_valid), 64'(0));
    chk("rst_errcnt",   64'(stat_err_cnt), 64'(0));
    sys_rst_n = 1'b1;
    tick();

    // single request from requester 1
    pg_a[1] = 64'h1000; off_a[1] = 12'h008; req_valid = 3'b010;
    txn("single", 3'b010, 5, 64'hDEADBEEF, 1'b0, 1'b0, 3'b010, 64'h1000, 12'h008);
    chk("single_errcnt", 64'(stat_err_cnt), 64'(0));

    // reset while in WAIT aborts the transaction
    pg_a[0] = 64'h2000; off_a[0] = 12'h010; req_valid = 3'b001;
    wait_start("rstw");
    req_valid = '0;
    tick(); tick();
    sys_rst_n = 1'b0;
    #1;
    chk("rstw_busy",     64'(busy),      64'(0));
    chk("rstw_grant",    64'(grant),     64'(0));
    chk("rstw_hm_start", 64'(hm_start),  64'(0));
    chk("rstw_page",     hm_page_addr,   64'(0));
    chk("rstw_off",      64'(hm_page_offset), 64'(0));
    chk("rstw_rsp_data", rsp_data,       64'(0));
    chk("rstw_rsp_err",  64'(rsp_error), 64'(0));
    chk("rstw_ack",      64'(req_ack),   64'(0));
    tick(); tick();
    sys_rst_n = 1'b1;
    hm_end = 1'b1; hm_data = 64'hBAD;
    tick();
    hm_end = 1'b0; hm_data = '0;
    repeat (3) begin
      tick();
      chk("rstw_late_rsp",  64'(rsp_valid), 64'(0));
      chk("rstw_late_busy", 64'(busy),      64'(0));
    end

    // fairness: all three held, order 0,1,2,0,1,2 from reset
    pg_a[0] = 64'hA000; pg_a[1] = 64'hA001; pg_a[2] = 64'hA002;
    off_a[0] = 12'h100; off_a[1] = 12'h101; off_a[2] = 12'h102;
    req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      g = 3'b001 << (t % 3);
      txn("fair", g, 1 + (t % 2), 64'h100 + 64'(t), 1'b0, 1'b0,
          (t == 5) ? 3'b111 : 3'b000, 64'hA000 + 64'(t % 3), 12'h100 + 12'(t % 3));
    end

    // error responses and counter
    req_valid = 3'b010;
    txn("err_tmo", 3'b010, 2, 64'h55, 1'b0, 1'b1, 3'b010, 64'hA001, 12'h101);
    chk("err_cnt1", 64'(stat_err_cnt), 64'(1));
    req_valid = 3'b001;
    txn("err_hm", 3'b001, 1, 64'h66, 1'b1, 1'b0, 3'b001, 64'hA000, 12'h100);
    chk("err_cnt2", 64'(stat_err_cnt), 64'(2));
    req_valid = 3'b100;
    txn("ok", 3'b100, 3, 64'h77, 1'b0, 1'b0, 3'b100, 64'hA002, 12'h102);
    chk("err_cnt_hold", 64'(stat_err_cnt), 64'(2));

    // hm_end outside WAIT is ignored; req_valid changes in WAIT don't disturb
    hm_end = 1'b1; hm_data = 64'hFFFF;
    tick();
    hm_end = 1'b0;
    chk("idle_end_busy", 64'(busy),      64'(0));
    chk("idle_end_rsp",  64'(rsp_valid), 64'(0));
    req_valid = 3'b001;
    wait_start("early");
    hm_end = 1'b1;
    tick();
    hm_end = 1'b0; hm_data = '0;
    chk("early_hs", 64'(hm_start), 64'(1));
    req_valid = 3'b110;
    tick();
    chk("early_hs2",   64'(hm_start),  64'(1));
    chk("early_rsp",   64'(rsp_valid), 64'(0));
    chk("early_grant", 64'(grant),     64'(3'b001));
    sb.push_back('{3'b001, 64'h88, 1'b0});
    hm_end = 1'b1; hm_data = 64'h88;
    tick();
    hm_end = 1'b0; hm_data = '0;
    tick();
    txn("after", 3'b010, 1, 64'h99, 1'b0, 1'b0, 3'b110, 64'hA001, 12'h101);

    // watchdog behaviour
    req_valid = 3'b100;
`ifdef CHECKER_HM_ARB_WATCHDOG_EN
    sb.push_back('{3'b100, 64'h0, 1'b1});
    wait_start("wd");
    req_valid = '0;
    repeat (16) tick();
    chk("wd_pre_rsp", 64'(rsp_valid), 64'(0));
    chk("wd_pre_hs",  64'(hm_start),  64'(1));
    tick();
    chk("wd_rsp",      64'(rsp_valid), 64'(3'b100));
    chk("wd_rsp_data", rsp_data,       64'(0));
    chk("wd_rsp_err",  64'(rsp_error), 64'(1));
    chk("wd_hs_drop",  64'(hm_start),  64'(0));
    tick();
    chk("wd_errcnt", 64'(stat_err_cnt), 64'(3));
`else
    wait_start("nowd");
    req_valid = '0;
    repeat (40) tick();
    chk("nowd_busy", 64'(busy),      64'(1));
    chk("nowd_hs",   64'(hm_start),  64'(1));
    chk("nowd_rsp",  64'(rsp_valid), 64'(0));
    sb.push_back('{3'b100, 64'h1234, 1'b0});
    hm_end = 1'b1; hm_data = 64'h1234;
    tick();
    hm_end = 1'b0; hm_data = '0;
    tick();
    chk("nowd_errcnt", 64'(stat_err_cnt), 64'(2));
`endif

    // saturation: preload near the top, then two more errors
    force dut.r_err_cnt = 16'hFFFE;
    tick();
    release dut.r_err_cnt;
    #1;
    chk("sat_pre", 64'(stat_err_cnt), 64'(16'hFFFE));
    req_valid = 3'b001;
    txn("sat1", 3'b001, 1, 64'hE1, 1'b1, 1'b0, 3'b001, 64'hA000, 12'h100);
    chk("sat_cnt1", 64'(stat_err_cnt), 64'(16'hFFFF));
    req_valid = 3'b001;
    txn("sat2", 3'b001, 1, 64'hE2, 1'b0, 1'b1, 3'b001, 64'hA000, 12'h100);
    chk("sat_cnt2", 64'(stat_err_cnt), 64'(16'hFFFF));

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/checker_hm_arbiter.md
CHECKER_HM_ARBITER -- requirements
Module: checker_hm_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the host-memory read engine (range 2..8).
REQ-002 Parameter TIMEOUT, default 1024: watchdog limit in sys_clk cycles per transaction (range 4..65535).
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester read request, held until acked.
REQ-007 req_page  in  N_REQ*64  per-requester 64-bit page address, slice i = requester i.
REQ-008 req_offset  in  N_REQ*12  per-requester 12-bit page offset.
REQ-009 req_ack  out  N_REQ  one-cycle one-hot pulse: request accepted.
REQ-010 rsp_valid  out  N_REQ  one-cycle one-hot pulse: response ready.
REQ-011 rsp_data  out  64  shared response data, valid with rsp_valid.
REQ-012 rsp_error  out  1  response failed, valid with rsp_valid.
REQ-013 hm_page_addr  out  64  page address to engine.
REQ-014 hm_page_offset  out  12  offset to engine.
REQ-015 hm_start  out  1  level request to engine.
REQ-016 hm_end  in  1  engine completion strobe.
REQ-017 hm_data  in  64  engine read data, valid with hm_end.
REQ-018 hm_error, hm_timeout  in  1 each  engine failure flags, sampled with hm_end.
REQ-019 grant  out  N_REQ  one-hot current owner, 0 when idle.
REQ-020 busy  out  1  high in any state but IDLE.
REQ-021 stat_err_cnt  out  16  saturating count of error responses.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, RESP, encoded 2 bits.
REQ-023 IDLE: on any req_valid, register round-robin winner into grant and latch its page/offset into hm_page_addr/hm_page_offset; next state ISSUE.
REQ-024 Round-robin: search starts at index (last winner + 1) mod N_REQ; after reset last winner = N_REQ-1, so requester 0 has first priority.
REQ-025 ISSUE: req_ack[winner] pulses one cycle, hm_start rises, watchdog loads 0; next state WAIT.
REQ-026 WAIT: hm_start held high; watchdog increments each cycle; on hm_end latch hm_data into rsp_data, rsp_error = hm_error|hm_timeout; next state RESP.
REQ-027 RESP: hm_start low, rsp_valid[winner] pulses one cycle, grant cleared at exit; next state IDLE.
REQ-028 Minimum request-to-response latency: 4 cycles (IDLE, ISSUE, WAIT with hm_end, RESP).
REQ-029 hm_end while not in WAIT is ignored; req_valid changes during WAIT do not affect current transaction.
REQ-030 Requests arriving in the RESP cycle are arbitrated in following IDLE cycle (one idle cycle between transactions, no back-to-back issue).
REQ-031 stat_err_cnt increments on every RESP with rsp_error=1, saturates at 16'hFFFF, never wraps.
REQ-032 A requester deasserting req_valid before ack (protocol violation) is not required to be handled; its latched request still completes.

Reset
REQ-033 Asserting sys_rst_n low immediately forces: state IDLE, grant 0, req_ack 0, rsp_valid 0, rsp_data 0, rsp_error 0, hm_start 0, hm_page_addr 0, hm_page_offset 0, busy 0, stat_err_cnt 0, last winner N_REQ-1.
REQ-034 Reset mid-transaction aborts with no rsp_valid; an hm_end arriving after release is ignored.

Configuration
REQ-035 Macro CHECKER_HM_ARB_WATCHDOG_EN defined: watchdog reaching TIMEOUT-1 in WAIT without hm_end moves to RESP with rsp_error=1, rsp_data=0, hm_start dropped.
REQ-036 Macro undefined: no watchdog counter is built; WAIT exits only on hm_end.

Structure
REQ-037 Shared checker package/header holds FSM state constants, HM_ADDR_W=64, HM_OFF_W=12, HM_DATA_W=64.
REQ-038 Round-robin selection in one combinational sub-module checker_rr_pick (inputs req vector, last winner; output one-hot winner).

Verification
REQ-039 Single: N_REQ=3, req_valid=3'b010, page 64'h1000, offset 12'h008, hm_end 5 cycles after hm_start with hm_data 64'hDEADBEEF -> req_ack=3'b010, rsp_valid=3'b010, rsp_data=64'hDEADBEEF, rsp_error=0.
REQ-040 Fairness: all three held valid for 6 transactions -> grant order 0,1,2,0,1,2.
REQ-041 Error: hm_end with hm_timeout=1 -> rsp_error=1, stat_err_cnt 0->1.
REQ-042 Watchdog (macro on, TIMEOUT=16): no hm_end -> rsp_valid 17 cycles after hm_start rise, rsp_error=1, rsp_data=0; macro off -> remains in WAIT.
REQ-043 Reset in WAIT: sys_rst_n low 2 cycles -> all outputs at reset values, late hm_end produces no rsp_valid.
REQ-044 Saturation: force 65536 error responses -> stat_err_cnt holds 16'hFFFF.
